soc_mem2_stream_reader: RTL

//   Avalon-MM read master for the 32-bit port (s2) of the dual-port on-chip key memory.

---
 rtl/soc_mem2_stream_reader_if.sv | 36 +++
 rtl/soc_mem2_stream_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/soc_mem2_stream_reader_if.sv
// Bus bundle for the s2 key-memory read master: run control, Avalon-MM port s2 and output stream.
// master = reader side; slave = memory/downstream/controller side.
interface soc_mem2_stream_reader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 12
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] address2;
   logic              chipselect2;
   logic              write2;
   logic [DATA_W-1:0] writedata2;
   logic [3:0]        byteenable2;
   logic              clken2;
   logic [DATA_W-1:0] readdata2;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  start, abort, base_addr, word_count, readdata2, out_ready,
      output busy, done, address2, chipselect2, write2, writedata2, byteenable2, clken2,
             out_data, out_valid
   );

   modport slave (
      output start, abort, base_addr, word_count, readdata2, out_ready,
      input  busy, done, address2, chipselect2, write2, writedata2, byteenable2, clken2,
             out_data, out_valid
   );
endinterface

// File: rtl/soc_mem2_stream_reader.sv
// Streams a run of words from memory port s2; first word valid 2 edges after start, 1 word/cycle.
// Downstream backpressure throttles issue through a 2-entry FIFO credit that includes the in-flight read.
module soc_mem2_stream_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2560,
   parameter int CNT_W  = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   soc_mem2_stream_reader_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_inflight;
   logic [DATA_W-1:0] r_fifo [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   logic              w_issue;
   logic              w_pop;
   logic              w_push;
   logic              w_abort;
   logic              w_credit_ok;
   logic [ADDR_W-1:0] w_addr_nxt;

   assign w_pop   = (r_count != 2'd0) && bus.out_ready;
   assign w_push  = r_inflight;
   assign w_abort = bus.abort && ((r_state == RUN) || (r_state == DRAIN));

   // A head popping this cycle frees its slot in time for the new read's data, keeping 1 word/cycle.
   assign w_credit_ok = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

   assign w_addr_nxt = (r_cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_cur_addr + ADDR_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.word_count == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               w_state_nxt = DONE;
            end else if (w_credit_ok) begin
               w_issue = 1'b1;
               if (r_remaining == CNT_W'(1)) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (bus.abort || (!r_inflight && (r_count == 2'd0))) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_fifo[0]   <= '0;
         r_fifo[1]   <= '0;
      end else begin
         if ((r_state == IDLE) && bus.start) begin
            r_cur_addr  <= bus.base_addr;
            r_remaining <= bus.word_count;
         end else if (w_issue) begin
            r_cur_addr  <= w_addr_nxt;
            r_remaining <= r_remaining - CNT_W'(1);
         end

         // Abort drops the returning read and empties the FIFO in one edge.
         if (w_abort) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
         end else begin
            r_inflight <= w_issue;
            if (w_push) begin
               r_fifo[r_wr_ptr] <= bus.readdata2;
               r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

   assign bus.address2    = r_cur_addr;
   assign bus.chipselect2 = w_issue;
   assign bus.clken2      = w_issue;
   assign bus.write2      = 1'b0;
   assign bus.writedata2  = '0;
   assign bus.byteenable2 = 4'hF;
   assign bus.busy        = (r_state == RUN) || (r_state == DRAIN);
   assign bus.done        = (r_state == DONE);
   assign bus.out_valid   = (r_count != 2'd0);
   assign bus.out_data    = r_fifo[r_rd_ptr];

endmodule
